// File: rtl/alu_issue_if.sv
// alu_issue_if: decode->issue->ALU handshake and operand bundle.
// Carries writeback bypass inputs alongside the issue channel.
interface alu_issue_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    in_srca;
    logic [DATA_WIDTH-1:0]    in_srcb;
    logic                     in_srcb_reg;
    logic [OPCODE_LENGTH-1:0] in_op;
    logic [REG_ADDR_W-1:0]    in_rs1;
    logic [REG_ADDR_W-1:0]    in_rs2;
    logic [REG_ADDR_W-1:0]    in_rd;
    logic                     wb_we;
    logic [REG_ADDR_W-1:0]    wb_rd;
    logic [DATA_WIDTH-1:0]    wb_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [REG_ADDR_W-1:0]    out_rd;

    modport slave (
        input  in_valid, in_srca, in_srcb, in_srcb_reg,
        input  in_op, in_rs1, in_rs2, in_rd,
        input  wb_we, wb_rd, wb_data,
        input  out_ready,
        output in_ready, out_valid,
        output SrcA, SrcB, Operation, out_rd
    );

    modport master (
        output in_valid, in_srca, in_srcb, in_srcb_reg,
        output in_op, in_rs1, in_rs2, in_rd,
        output wb_we, wb_rd, wb_data,
        output out_ready,
        input  in_ready, out_valid,
        input  SrcA, SrcB, Operation, out_rd
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register with 2-entry skid (M drives ALU, S spare).
// Optional writeback bypass into held operands: define ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    alu_issue_if.slave  bus
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    a;
        logic [DATA_WIDTH-1:0]    b;
        logic [OPCODE_LENGTH-1:0] op;
        logic [REG_ADDR_W-1:0]    rd;
`ifdef ALU_ISSUE_FWD_EN
        logic [REG_ADDR_W-1:0]    rs1;
        logic [REG_ADDR_W-1:0]    rs2;
        logic                     breg;
`endif
    } ent_t;

    logic r_in_ready;
    logic r_m_valid;
    logic r_s_valid;
    ent_t r_m;
    ent_t r_s;

    logic w_acc;
    logic w_m_free;
    logic w_nm_valid;
    logic w_ns_valid;
    ent_t w_nm;
    ent_t w_ns;

    ent_t w_in;
    ent_t w_in_f;
    ent_t w_m_f;
    ent_t w_s_f;

    // Pack the incoming op; source indices only matter for bypass.
    always_comb begin
        w_in     = '0;
        w_in.a   = bus.in_srca;
        w_in.b   = bus.in_srcb;
        w_in.op  = bus.in_op;
        w_in.rd  = bus.in_rd;
`ifdef ALU_ISSUE_FWD_EN
        w_in.rs1  = bus.in_rs1;
        w_in.rs2  = bus.in_rs2;
        w_in.breg = bus.in_srcb_reg;
`endif
    end

`ifdef ALU_ISSUE_FWD_EN
    function automatic ent_t fwd(
        input ent_t                  e,
        input logic                  en,
        input logic [REG_ADDR_W-1:0] wrd,
        input logic [DATA_WIDTH-1:0] wdat
    );
        ent_t r;
        logic hit;
        r   = e;
        hit = en && (wrd != '0);
        if (hit && (wrd == e.rs1))
            r.a = wdat;
        if (hit && e.breg && (wrd == e.rs2))
            r.b = wdat;
        return r;
    endfunction

    logic w_wb_we;
    assign w_wb_we = bus.wb_we;

    // Bypass view of the input and of each live entry.
    always_comb begin
        w_in_f = fwd(w_in, w_wb_we, bus.wb_rd, bus.wb_data);
        w_m_f  = fwd(r_m, w_wb_we && r_m_valid, bus.wb_rd, bus.wb_data);
        w_s_f  = fwd(r_s, w_wb_we && r_s_valid, bus.wb_rd, bus.wb_data);
    end
`else
    // Operands are captured and held verbatim.
    always_comb begin
        w_in_f = w_in;
        w_m_f  = r_m;
        w_s_f  = r_s;
    end
`endif

    assign w_acc    = bus.in_valid && r_in_ready;
    assign w_m_free = !r_m_valid || bus.out_ready;

    // Next-state of the M/S pair; S always refills M first to keep FIFO order.
    always_comb begin
        w_nm_valid = r_m_valid;
        w_ns_valid = r_s_valid;
        w_nm       = w_m_f;
        w_ns       = w_s_f;
        if (w_m_free) begin
            if (r_s_valid) begin
                w_nm_valid = 1'b1;
                w_nm       = w_s_f;
                if (w_acc) begin
                    w_ns_valid = 1'b1;
                    w_ns       = w_in_f;
                end else begin
                    w_ns_valid = 1'b0;
                end
            end else if (w_acc) begin
                w_nm_valid = 1'b1;
                w_nm       = w_in_f;
            end else begin
                w_nm_valid = 1'b0;
            end
        end else if (w_acc) begin
            w_ns_valid = 1'b1;
            w_ns       = w_in_f;
        end
    end

    // Entry registers; flush kills valids but leaves data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
            r_m        <= '0;
            r_s        <= '0;
        end else if (flush) begin
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_m_valid  <= w_nm_valid;
            r_s_valid  <= w_ns_valid;
            r_in_ready <= !w_ns_valid;
            r_m        <= w_nm;
            r_s        <= w_ns;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_m_valid;
    assign bus.SrcA      = r_m.a;
    assign bus.SrcB      = r_m.b;
    assign bus.Operation = r_m.op;
    assign bus.out_rd    = r_m.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed checks of alu_issue_stage.
// Bypass expectations follow ALU_ISSUE_FWD_EN.
module tb_alu_issue_stage;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_vec;
    int   n_bad;

    alu_issue_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5)) bus ();

    alu_issue_stage #(
        .DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(
        input logic        v,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        breg,
        input logic [3:0]  op,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd
    );
        bus.in_valid    = v;
        bus.in_srca     = a;
        bus.in_srcb     = b;
        bus.in_srcb_reg = breg;
        bus.in_op       = op;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_rd       = rd;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0);
        bus.wb_we     = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 32'h0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // reset state
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_srca", bus.SrcA, 32'h0);
        chk("rst_op", {28'b0, bus.Operation}, 32'h0);

        // reset mid-stream with two held ops
        tick();
        drive(1'b1, 32'hA1, 32'hB1, 1'b1, 4'h1, 5'd0, 5'd0, 5'd1);
        tick();
        drive(1'b1, 32'hA2, 32'hB2, 1'b1, 4'h2, 5'd0, 5'd0, 5'd2);
        tick();
        bus.in_valid = 1'b0;
        chk("hold2_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("hold2_srca", bus.SrcA, 32'hA1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mrst_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("mrst_srca", bus.SrcA, 32'h0);
        chk("mrst_srcb", bus.SrcB, 32'h0);
        chk("mrst_op", {28'b0, bus.Operation}, 32'h0);
        chk("mrst_rd", {27'b0, bus.out_rd}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_noemit", {31'b0, bus.out_valid}, 32'd0);
        end

        // streaming: 8 back-to-back ops
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h1000 + k, 32'h2000 + k, 1'b1,
                  4'(k), 5'd0, 5'd0, 5'(k + 1));
            tick();
            chk("str_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("str_srca", bus.SrcA, 32'h1000 + k);
            chk("str_srcb", bus.SrcB, 32'h2000 + k);
            chk("str_op", {28'b0, bus.Operation}, 32'(k));
            chk("str_rd", {27'b0, bus.out_rd}, 32'(k + 1));
            chk("str_ready", {31'b0, bus.in_ready}, 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("str_end", {31'b0, bus.out_valid}, 32'd0);

        // backpressure: 3 ops offered, 2 held
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h31, 32'h0, 1'b1, 4'h3, 5'd0, 5'd0, 5'd3);
        tick();
        chk("bp1_srca", bus.SrcA, 32'h31);
        chk("bp1_ready", {31'b0, bus.in_ready}, 32'd1);
        drive(1'b1, 32'h32, 32'h0, 1'b1, 4'h3, 5'd0, 5'd0, 5'd3);
        tick();
        chk("bp2_srca", bus.SrcA, 32'h31);
        chk("bp2_ready", {31'b0, bus.in_ready}, 32'd0);
        drive(1'b1, 32'h33, 32'h0, 1'b1, 4'h3, 5'd0, 5'd0, 5'd3);
        tick();
        chk("bp3_srca", bus.SrcA, 32'h31);
        chk("bp3_ready", {31'b0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_out2_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("bp_out2", bus.SrcA, 32'h32);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_out3", bus.SrcA, 32'h33);
        tick();
        chk("bp_end", {31'b0, bus.out_valid}, 32'd0);

        // flush with 2 held plus one offered
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h41, 32'h0, 1'b1, 4'h4, 5'd0, 5'd0, 5'd4);
        tick();
        drive(1'b1, 32'h42, 32'h0, 1'b1, 4'h4, 5'd0, 5'd0, 5'd4);
        tick();
        drive(1'b1, 32'h43, 32'h0, 1'b1, 4'h4, 5'd0, 5'd0, 5'd4);
        flush = 1'b1;
        tick();
        chk("fl_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("fl_ready", {31'b0, bus.in_ready}, 32'd1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("fl_noemit", {31'b0, bus.out_valid}, 32'd0);
        end

        // bypass into held M (immediate B)
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'h77, 1'b0, 4'b0010, 5'd5, 5'd5, 5'd3);
        tick();
        bus.in_valid = 1'b0;
        chk("fw_srca0", bus.SrcA, 32'h0);
        chk("fw_op", {28'b0, bus.Operation}, 32'h2);
        bus.wb_we   = 1'b1;
        bus.wb_rd   = 5'd5;
        bus.wb_data = 32'h1234;
        tick();
        chk("fw_srca", bus.SrcA, FWD ? 32'h1234 : 32'h0);
        chk("fw_imm", bus.SrcB, 32'h77);
        bus.wb_rd   = 5'd0;
        bus.wb_data = 32'h9999;
        tick();
        chk("fw_x0_srca", bus.SrcA, FWD ? 32'h1234 : 32'h0);
        chk("fw_x0_imm", bus.SrcB, 32'h77);
        bus.wb_we = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("fw_drain", {31'b0, bus.out_valid}, 32'd0);

        // bypass on accept (register B)
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h1, 32'h2, 1'b1, 4'h3, 5'd7, 5'd8, 5'd9);
        bus.wb_we   = 1'b1;
        bus.wb_rd   = 5'd8;
        bus.wb_data = 32'hBEEF;
        tick();
        bus.wb_we = 1'b0;
        chk("fwa_srca", bus.SrcA, 32'h1);
        chk("fwa_srcb", bus.SrcB, FWD ? 32'hBEEF : 32'h2);

        // bypass into held S
        drive(1'b1, 32'h10, 32'h20, 1'b1, 4'h5, 5'd6, 5'd6, 5'd10);
        tick();
        bus.in_valid = 1'b0;
        bus.wb_we    = 1'b1;
        bus.wb_rd    = 5'd6;
        bus.wb_data  = 32'hCAFE;
        tick();
        bus.wb_we = 1'b0;
        chk("fws_m_srca", bus.SrcA, 32'h1);
        bus.out_ready = 1'b1;
        tick();
        chk("fws_srca", bus.SrcA, FWD ? 32'hCAFE : 32'h10);
        chk("fws_srcb", bus.SrcB, FWD ? 32'hCAFE : 32'h20);
        chk("fws_rd", {27'b0, bus.out_rd}, 32'd10);
        tick();
        chk("fws_end", {31'b0, bus.out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
